sad_disparity: RTL and testbench

- Stereo matching stage directly downstream of the 5x5 smoothing filter.
- Consumes the filtered left and right pixel streams, row-aligned and in lockstep.
- Per left pixel: computes a horizontal 1xWIN sum-of-absolute-differences cost against the right stream for each disparity 0..MAX_DISP-1.
- Emits the winner-take-all disparity, its cost and the adjusted coordinates to the depth/display stage.

---
 rtl/stereo_pkg.sv | 38 +++
 rtl/wta_min_tree.sv | 90 +++++++++
 rtl/sad_disparity.sv | 147 ++++++++++++++
 tb/tb_sad_disparity.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared constants and types for the stereo SAD disparity stage.
// Optional macro SAD_UNIQUE_EN adds the uniqueness bookkeeping field to meta_t.
package stereo_pkg;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned COORD_W  = 13;
   localparam int unsigned MAX_DISP = 16;
   localparam int unsigned WIN      = 5;
   localparam int unsigned UNIQ_THR = 8;

   localparam int unsigned COST_W   = PIX_W + $clog2(WIN);
   localparam int unsigned DISP_W   = $clog2(MAX_DISP);
   localparam int unsigned HIST_MAX = MAX_DISP + WIN - 1;
   localparam int unsigned HIST_W   = $clog2(HIST_MAX + 1);
   localparam int unsigned LAT      = 3 + DISP_W;

   typedef logic [PIX_W-1:0]   pix_t;
   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [COST_W-1:0]  cost_t;
   typedef logic [DISP_W-1:0]  disp_t;
   typedef logic [HIST_W-1:0]  hist_t;

   localparam cost_t COST_MAX = '1;

   typedef struct packed {
      logic   valid;
`ifdef SAD_UNIQUE_EN
      logic   multi;  // at least two disparities legal
`endif
      coord_t row;
      coord_t col;
   } meta_t;

   function automatic pix_t abs_diff(input pix_t a, input pix_t b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/wta_min_tree.sv
// Pipelined winner-take-all min tree, one register per level, lower index wins ties.
// With SAD_UNIQUE_EN the tree also tracks the second-lowest cost.
module wta_min_tree
   import stereo_pkg::*;
#(
   parameter int unsigned MaxDisp = MAX_DISP
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [MaxDisp-1:0][COST_W-1:0] cost_i,
   output cost_t                          min_o,
   output logic [$clog2(MaxDisp)-1:0]     idx_o
`ifdef SAD_UNIQUE_EN
   ,
   output cost_t                          min2_o
`endif
);

   localparam int unsigned Levels = $clog2(MaxDisp);
   localparam int unsigned Nodes  = MaxDisp - 1;

   typedef logic [Levels-1:0] idx_t;

   // Levels are packed back to back: level l starts at MaxDisp - (MaxDisp >> l).
   cost_t min_q  [Nodes];
   idx_t  idx_q  [Nodes];
`ifdef SAD_UNIQUE_EN
   cost_t min2_q [Nodes];
`endif

   for (genvar l = 0; l < Levels; l++) begin : g_lvl
      localparam int unsigned Off = MaxDisp - (MaxDisp >> l);
      for (genvar n = 0; n < (MaxDisp >> (l + 1)); n++) begin : g_node
         cost_t a_min, b_min;
         idx_t  a_idx, b_idx;
`ifdef SAD_UNIQUE_EN
         cost_t a_min2, b_min2;
`endif
         if (l == 0) begin : g_leaf
            assign a_min  = cost_i[2*n];
            assign b_min  = cost_i[2*n+1];
            assign a_idx  = idx_t'(2 * n);
            assign b_idx  = idx_t'(2 * n + 1);
`ifdef SAD_UNIQUE_EN
            assign a_min2 = COST_MAX;
            assign b_min2 = COST_MAX;
`endif
         end else begin : g_inner
            localparam int unsigned Src = MaxDisp - (MaxDisp >> (l - 1)) + 2 * n;
            assign a_min  = min_q[Src];
            assign b_min  = min_q[Src+1];
            assign a_idx  = idx_q[Src];
            assign b_idx  = idx_q[Src+1];
`ifdef SAD_UNIQUE_EN
            assign a_min2 = min2_q[Src];
            assign b_min2 = min2_q[Src+1];
`endif
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               min_q[Off+n]  <= '0;
               idx_q[Off+n]  <= '0;
`ifdef SAD_UNIQUE_EN
               min2_q[Off+n] <= '0;
`endif
            end else if (a_min <= b_min) begin
               min_q[Off+n]  <= a_min;
               idx_q[Off+n]  <= a_idx;
`ifdef SAD_UNIQUE_EN
               min2_q[Off+n] <= (b_min < a_min2) ? b_min : a_min2;
`endif
            end else begin
               min_q[Off+n]  <= b_min;
               idx_q[Off+n]  <= b_idx;
`ifdef SAD_UNIQUE_EN
               min2_q[Off+n] <= (a_min < b_min2) ? a_min : b_min2;
`endif
            end
         end
      end
   end

   assign min_o  = min_q[Nodes-1];
   assign idx_o  = idx_q[Nodes-1];
`ifdef SAD_UNIQUE_EN
   assign min2_o = min2_q[Nodes-1];
`endif

endmodule

// File: rtl/sad_disparity.sv
// 1xWIN SAD stereo matcher with winner-take-all disparity selection.
// Optional macro SAD_UNIQUE_EN adds the disp_ok uniqueness output.
module sad_disparity
   import stereo_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   input  pix_t   pix_l,
   input  pix_t   pix_r,
   input  coord_t row,
   input  coord_t col,
   output logic   out_valid,
   output disp_t  disp,
   output cost_t  cost_min,
   output coord_t rowout,
   output coord_t colout
`ifdef SAD_UNIQUE_EN
   ,
   output logic   disp_ok
`endif
);

   pix_t  l_q [WIN];
   pix_t  r_q [HIST_MAX];
   hist_t hist_q, hist_d;
   meta_t meta_q [LAT];
   meta_t meta_d;

   pix_t                  diff_q [MAX_DISP][WIN];
   logic  [MAX_DISP-1:0]  legal_q;
   cost_t [MAX_DISP-1:0]  sum_d, sum_q;

   cost_t tree_min;
   disp_t tree_idx;
`ifdef SAD_UNIQUE_EN
   cost_t tree_min2;
`endif

   // hist counts pixels of the current row including this one, so col==0 restarts at 1.
   always_comb begin
      hist_d = hist_q;
      if (col == '0) begin
         hist_d = hist_t'(1);
      end else if (hist_q < hist_t'(HIST_MAX)) begin
         hist_d = hist_q + hist_t'(1);
      end
   end

   always_comb begin
      meta_d       = '0;
      meta_d.valid = in_valid;
      meta_d.row   = row;
      meta_d.col   = col - coord_t'((WIN - 1) / 2);
`ifdef SAD_UNIQUE_EN
      meta_d.multi = (hist_d >= hist_t'(WIN + 1));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(WIN); k++) l_q[k] <= '0;
         for (int k = 0; k < int'(HIST_MAX); k++) r_q[k] <= '0;
         hist_q <= '0;
      end else if (in_valid) begin
         l_q[0] <= pix_l;
         r_q[0] <= pix_r;
         for (int k = 1; k < int'(WIN); k++) l_q[k] <= l_q[k-1];
         for (int k = 1; k < int'(HIST_MAX); k++) r_q[k] <= r_q[k-1];
         hist_q <= hist_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(LAT); i++) meta_q[i] <= '0;
      end else begin
         meta_q[0] <= meta_d;
         for (int i = 1; i < int'(LAT); i++) meta_q[i] <= meta_q[i-1];
      end
   end

   always_comb begin
      sum_d = '0;
      for (int d = 0; d < int'(MAX_DISP); d++) begin
         for (int k = 0; k < int'(WIN); k++) begin
            sum_d[d] = sum_d[d] + cost_t'(diff_q[d][k]);
         end
         if (!legal_q[d]) sum_d[d] = COST_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < int'(MAX_DISP); d++) begin
            for (int k = 0; k < int'(WIN); k++) diff_q[d][k] <= '0;
         end
         legal_q <= '0;
         sum_q   <= '0;
      end else begin
         for (int d = 0; d < int'(MAX_DISP); d++) begin
            for (int k = 0; k < int'(WIN); k++) diff_q[d][k] <= abs_diff(l_q[k], r_q[k+d]);
            legal_q[d] <= (int'(hist_q) >= d + int'(WIN));
         end
         sum_q <= sum_d;
      end
   end

   wta_min_tree #(
      .MaxDisp (MAX_DISP)
   ) u_tree (
      .clk    (clk),
      .rst    (rst),
      .cost_i (sum_q),
      .min_o  (tree_min),
      .idx_o  (tree_idx)
`ifdef SAD_UNIQUE_EN
      ,
      .min2_o (tree_min2)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         disp      <= '0;
         cost_min  <= '0;
         rowout    <= '0;
         colout    <= '0;
`ifdef SAD_UNIQUE_EN
         disp_ok   <= 1'b0;
`endif
      end else begin
         out_valid <= meta_q[LAT-1].valid;
         if (meta_q[LAT-1].valid) begin
            disp     <= tree_idx;
            cost_min <= tree_min;
            rowout   <= meta_q[LAT-1].row;
            colout   <= meta_q[LAT-1].col;
`ifdef SAD_UNIQUE_EN
            disp_ok  <= meta_q[LAT-1].multi && ((tree_min2 - tree_min) > cost_t'(UNIQ_THR));
`endif
         end
      end
   end

endmodule

// File: tb/tb_sad_disparity.sv
// Scoreboard bench for sad_disparity: a behavioural SAD/WTA model predicts every output.
module tb_sad_disparity;
   import stereo_pkg::*;

   logic   clk = 1'b0;
   logic   rst, in_valid;
   pix_t   pix_l, pix_r;
   coord_t row, col;
   logic   out_valid;
   disp_t  disp;
   cost_t  cost_min;
   coord_t rowout, colout;
`ifdef SAD_UNIQUE_EN
   logic   disp_ok;
`endif

   sad_disparity u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .pix_l     (pix_l),
      .pix_r     (pix_r),
      .row       (row),
      .col       (col),
      .out_valid (out_valid),
      .disp      (disp),
      .cost_min  (cost_min),
      .rowout    (rowout),
      .colout    (colout)
`ifdef SAD_UNIQUE_EN
      ,
      .disp_ok   (disp_ok)
`endif
   );

   typedef struct {
      int cyc;
      int disp;
      int cost;
      int row;
      int col;
      bit ok;
   } exp_t;

   exp_t sb[$];
   int   lh[$];
   int   rh[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   hold_chk = 1'b0;
   int   last_disp = 0, last_cost = 0, last_row = 0, last_col = 0;

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d required=finish", cyc);
      $fatal(1);
   end

   function automatic int pat1(int c);
      return (7 * c) % 256;
   endfunction

   function automatic int pat2(int c);
      return (13 * c + 5) % 256;
   endfunction

   // Predict the result for a pixel accepted at the next rising edge.
   function automatic void model_push(int l, int r, int rw, int cl);
      exp_t e;
      int   best, best2, bidx, nleg, c;
      if (cl == 0) begin
         lh.delete();
         rh.delete();
      end
      lh.push_front(l);
      rh.push_front(r);
      if (lh.size() > int'(HIST_MAX)) begin
         void'(lh.pop_back());
         void'(rh.pop_back());
      end
      best  = 1 << 30;
      best2 = 1 << 30;
      bidx  = 0;
      nleg  = 0;
      for (int d = 0; d < int'(MAX_DISP); d++) begin
         if (lh.size() >= d + int'(WIN)) begin
            nleg++;
            c = 0;
            for (int k = 0; k < int'(WIN); k++) begin
               c += (lh[k] > rh[k+d]) ? lh[k] - rh[k+d] : rh[k+d] - lh[k];
            end
         end else begin
            c = (1 << COST_W) - 1;
         end
         if (c < best) begin
            best2 = best;
            best  = c;
            bidx  = d;
         end else if (c < best2) begin
            best2 = c;
         end
      end
      e.cyc  = cyc + 1 + int'(LAT);
      e.disp = bidx;
      e.cost = best;
      e.row  = rw;
      e.col  = (cl - (int'(WIN) - 1) / 2) & ((1 << COORD_W) - 1);
      e.ok   = (nleg >= 2) && (best2 - best > int'(UNIQ_THR));
      sb.push_back(e);
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output cyc=%0d disp=%0d cost=%0d row=%0d col=%0d",
                        cyc, disp, cost_min, rowout, colout);
            end else begin
               e = sb.pop_front();
               checks++;
               if (cyc !== e.cyc) begin
                  errors++;
                  $display("FAIL latency got cyc=%0d required cyc=%0d", cyc, e.cyc);
               end
               checks++;
               if (disp !== disp_t'(e.disp) || cost_min !== cost_t'(e.cost) ||
                   rowout !== coord_t'(e.row) || colout !== coord_t'(e.col)) begin
                  errors++;
                  $display("FAIL result got disp=%0d cost=%0d row=%0d col=%0d required disp=%0d cost=%0d row=%0d col=%0d",
                           disp, cost_min, rowout, colout, e.disp, e.cost, e.row, e.col);
               end
`ifdef SAD_UNIQUE_EN
               checks++;
               if (disp_ok !== e.ok) begin
                  errors++;
                  $display("FAIL disp_ok got %0b required %0b (row=%0d col=%0d)",
                           disp_ok, e.ok, e.row, e.col);
               end
`endif
               last_disp = e.disp;
               last_cost = e.cost;
               last_row  = e.row;
               last_col  = e.col;
            end
         end else if (hold_chk) begin
            checks++;
            if (disp !== disp_t'(last_disp) || cost_min !== cost_t'(last_cost) ||
                rowout !== coord_t'(last_row) || colout !== coord_t'(last_col)) begin
               errors++;
               $display("FAIL hold got disp=%0d cost=%0d row=%0d col=%0d required disp=%0d cost=%0d row=%0d col=%0d",
                        disp, cost_min, rowout, colout, last_disp, last_cost, last_row, last_col);
            end
         end
      end
   end

   task automatic step(input bit v, input int l, input int r, input int rw, input int cl);
      @(posedge clk);
      #1;
      in_valid = v;
      pix_l    = pix_t'(l);
      pix_r    = pix_t'(r);
      row      = coord_t'(rw);
      col      = coord_t'(cl);
      if (v) model_push(l, r, rw, cl);
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s out_valid got %0b required 0", name, out_valid);
      end
      checks++;
      if (disp !== '0 || cost_min !== '0) begin
         errors++;
         $display("FAIL %s disp/cost got %0d/%0d required 0/0", name, disp, cost_min);
      end
      checks++;
      if (rowout !== '0 || colout !== '0) begin
         errors++;
         $display("FAIL %s row/col got %0d/%0d required 0/0", name, rowout, colout);
      end
`ifdef SAD_UNIQUE_EN
      checks++;
      if (disp_ok !== 1'b0) begin
         errors++;
         $display("FAIL %s disp_ok got %0b required 0", name, disp_ok);
      end
`endif
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      pix_l    = '0;
      pix_r    = '0;
      row      = '0;
      col      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_constant();
      for (int c = 0; c < 64; c++) step(1'b1, 100, 100, 0, c);
      drain();
   endtask

   task automatic test_shift();
      for (int c = 0; c < 64; c++) step(1'b1, pat1(c), pat1(c + 4), 1, c);
   endtask

   // Runs straight on from row 1 so the row-2 start follows col 63 directly.
   task automatic test_row_change();
      for (int c = 0; c < 64; c++) step(1'b1, pat2(c), pat2(c + 2), 2, c);
      drain();
   endtask

   task automatic test_toggle();
      hold_chk = 1'b1;
      for (int c = 0; c < 64; c++) begin
         step(1'b1, pat1(c), pat1(c + 4), 5, c);
         step(1'b0, 0, 0, 0, 0);
      end
      drain();
      hold_chk = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 20; c++) step(1'b1, pat1(c), pat1(c + 4), 3, c);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b1;
      pix_l    = pix_t'(pat1(20));
      pix_r    = pix_t'(pat1(24));
      row      = coord_t'(3);
      col      = coord_t'(20);
      // Anything due at or after the reset edge is discarded.
      while (sb.size() != 0 && sb[sb.size()-1].cyc >= cyc + 1) void'(sb.pop_back());
      lh.delete();
      rh.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_zero("reset_mid");
      last_disp = 0;
      last_cost = 0;
      last_row  = 0;
      last_col  = 0;
      for (int c = 21; c < 64; c++) step(1'b1, pat1(c), pat1(c + 4), 3, c);
      drain();
   endtask

   initial begin
      test_reset();
      test_constant();
      test_shift();
      test_row_change();
      test_toggle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
